// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store alignment sequencer.
package lsu_pkg;

    // Access size encodings; nbytes = 1 << size.
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StReq0,
        StWait0,
        StReq1,
        StWait1,
        StResp
    } lsuState_e;

    // Number of bytes touched by an access of the given size.
    function automatic int unsigned nBytes(input logic [1:0] size);
        return 32'd1 << size;
    endfunction

    // Byte lane offset of an address within a bus word of 'bytes' lanes.
    function automatic int unsigned laneOff(input logic [31:0] addr, input int unsigned bytes);
        return addr & (bytes - 32'd1);
    endfunction

endpackage

// File: rtl/lsu_be_gen.sv
// Combinational lane steering: byte enables and write data across two beats,
// split detection, and load-data merge with sign/zero extension.
module lsu_be_gen
    import lsu_pkg::*;
#(
    parameter int unsigned DW = 32,
    localparam int unsigned BYTES = DW / 8,
    localparam int unsigned OW = $clog2(BYTES)
) (
    input  logic [1:0]         size_i,
    input  logic [OW-1:0]      off_i,
    input  logic               isSigned_i,
    input  logic [DW-1:0]      wdata_i,
    input  logic [DW-1:0]      rdata0_i,
    input  logic [DW-1:0]      rdata1_i,
    output logic [2*BYTES-1:0] be2_o,
    output logic [2*DW-1:0]    wd2_o,
    output logic               split_o,
    output logic               tooBig_o,
    output logic [DW-1:0]      rdata_o
);

    int unsigned         nb;
    logic [2*BYTES:0]    mask;
    logic [2*BYTES-1:0]  be2;
    logic [2*DW-1:0]     merged;
    logic [2*DW-1:0]     signShift;
    logic [DW-1:0]       keep;
    logic                sgnBit;

    // Steer store lanes / enables and assemble extended load data.
    always_comb begin
        nb        = nBytes(size_i);
        mask      = (2*BYTES+1)'((33'd1 << nb) - 33'd1);
        be2       = mask[2*BYTES-1:0] << off_i;
        be2_o     = be2;
        wd2_o     = {{DW{1'b0}}, wdata_i} << {off_i, 3'b000};
        split_o   = |be2[2*BYTES-1:BYTES];
        tooBig_o  = nb > BYTES;
        merged    = {rdata1_i, rdata0_i} >> {off_i, 3'b000};
        signShift = '0;
        sgnBit    = 1'b0;
        keep      = '1;
        if (nb < BYTES) begin
            signShift = merged >> (8 * nb - 1);
            sgnBit    = isSigned_i & signShift[0];
            keep      = ~({DW{1'b1}} << (8 * nb));
        end
        rdata_o = (merged[DW-1:0] & keep) | ({DW{sgnBit}} & ~keep);
    end

endmodule

// File: rtl/lsu_align_seq.sv
// MEM-stage load/store alignment sequencer: one access per request, split into
// two memory beats when it crosses a bus-word boundary.
module lsu_align_seq
    import lsu_pkg::*;
#(
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 32,
    parameter bit          SPLIT_EN = 1'b1,
    localparam int unsigned BYTES   = DW / 8,
    localparam int unsigned OW      = $clog2(BYTES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_signed,
    input  logic [AW-1:0]    req_addr,
    input  logic [DW-1:0]    req_wdata,
    output logic             rsp_valid,
    output logic [DW-1:0]    rsp_rdata,
    output logic             rsp_err,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [BYTES-1:0] mem_be,
    output logic [DW-1:0]    mem_wdata,
    input  logic             mem_rvalid,
    input  logic [DW-1:0]    mem_rdata
);

    lsuState_e     stateQ, stateD;
    logic          weQ, weD;
    logic [1:0]    sizeQ, sizeD;
    logic          sgnQ, sgnD;
    logic [AW-1:0] addrQ, addrD;
    logic [DW-1:0] wdataQ, wdataD;
    logic          errQ, errD;
    logic [DW-1:0] rd0Q, rd0D;
    logic [DW-1:0] rd1Q, rd1D;

    logic               idle;
    logic [1:0]         genSize;
    logic               genSgn;
    logic [AW-1:0]      genAddr;
    logic [DW-1:0]      genWdata;
    logic [OW-1:0]      off;
    logic [2*BYTES-1:0] be2;
    logic [2*DW-1:0]    wd2;
    logic               split;
    logic               tooBig;
    logic               reqErr;
    logic [DW-1:0]      ext;
    logic [AW-1:0]      base;

    // In IDLE the generator looks at the live request so errors/splits are known
    // at acceptance; afterwards it works from the captured copy.
    always_comb begin
        idle     = (stateQ == StIdle);
        genSize  = idle ? req_size   : sizeQ;
        genSgn   = idle ? req_signed : sgnQ;
        genAddr  = idle ? req_addr   : addrQ;
        genWdata = idle ? req_wdata  : wdataQ;
        off      = OW'(laneOff(32'(genAddr), BYTES));
        reqErr   = tooBig | (split & ~SPLIT_EN);
    end

    lsu_be_gen #(
        .DW(DW)
    ) u_beGen (
        .size_i    (genSize),
        .off_i     (off),
        .isSigned_i(genSgn),
        .wdata_i   (genWdata),
        .rdata0_i  (rd0Q),
        .rdata1_i  (rd1Q),
        .be2_o     (be2),
        .wd2_o     (wd2),
        .split_o   (split),
        .tooBig_o  (tooBig),
        .rdata_o   (ext)
    );

    // State, captured request and returned beat data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= StIdle;
            weQ    <= 1'b0;
            sizeQ  <= 2'd0;
            sgnQ   <= 1'b0;
            addrQ  <= '0;
            wdataQ <= '0;
            errQ   <= 1'b0;
            rd0Q   <= '0;
            rd1Q   <= '0;
        end else begin
            stateQ <= stateD;
            weQ    <= weD;
            sizeQ  <= sizeD;
            sgnQ   <= sgnD;
            addrQ  <= addrD;
            wdataQ <= wdataD;
            errQ   <= errD;
            rd0Q   <= rd0D;
            rd1Q   <= rd1D;
        end
    end

    // Next-state logic; only the handshake relevant to the current state acts.
    always_comb begin
        stateD = stateQ;
        weD    = weQ;
        sizeD  = sizeQ;
        sgnD   = sgnQ;
        addrD  = addrQ;
        wdataD = wdataQ;
        errD   = errQ;
        rd0D   = rd0Q;
        rd1D   = rd1Q;
        unique case (stateQ)
            StIdle: begin
                if (req_valid) begin
                    weD    = req_we;
                    sizeD  = req_size;
                    sgnD   = req_signed;
                    addrD  = req_addr;
                    wdataD = req_wdata;
                    errD   = reqErr;
                    rd0D   = '0;
                    rd1D   = '0;
                    stateD = reqErr ? StResp : StReq0;
                end
            end
            StReq0: begin
                if (mem_ready) stateD = weQ ? (split ? StReq1 : StResp) : StWait0;
            end
            StWait0: begin
                if (mem_rvalid) begin
                    rd0D   = mem_rdata;
                    stateD = split ? StReq1 : StResp;
                end
            end
            StReq1: begin
                if (mem_ready) stateD = weQ ? StResp : StWait1;
            end
            StWait1: begin
                if (mem_rvalid) begin
                    rd1D   = mem_rdata;
                    stateD = StResp;
                end
            end
            StResp:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    // Outputs decode straight from state so mem_valid drops with reset.
    always_comb begin
        base      = {addrQ[AW-1:OW], {OW{1'b0}}};
        req_ready = idle;
        mem_valid = (stateQ == StReq0) | (stateQ == StReq1);
        mem_we    = mem_valid & weQ;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        if (stateQ == StReq0) begin
            mem_addr  = base;
            mem_be    = be2[BYTES-1:0];
            mem_wdata = wd2[DW-1:0];
        end else if (stateQ == StReq1) begin
            mem_addr  = base + AW'(BYTES);
            mem_be    = be2[2*BYTES-1:BYTES];
            mem_wdata = wd2[2*DW-1:DW];
        end
        rsp_valid = (stateQ == StResp);
        rsp_err   = rsp_valid & errQ;
        rsp_rdata = (rsp_valid & ~errQ & ~weQ) ? ext : '0;
    end

endmodule
